xrv_fetch: RTL and testbench
============================

# xrv_fetch

Instruction-fetch stage of the xriscv core. It owns the program counter and issues in-order requests on a pipelined instruction-memory port. It buffers returned instructions in a small FIFO and presents them, with their PC, to decode. It consumes the control block's `stalling`, `jmp` and `jmp_addr`: stalls hold the head instruction, and jumps redirect the PC and discard all wrong-path work.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 4: instruction FIFO entries, and also the cap on outstanding plus buffered fetches. Allowed range ≥2.

Ports:
- `clk`  in  1  clock. One clock only.
- `rstb`  in  1  reset, asynchronous, active-low.
- `stalling`  in  1  from control. While high, the head instruction is held and not consumed.
- `jmp`  in  1  from control. Redirects fetch.
- `jmp_addr`  in  32  redirect target, valid when `jmp`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_gnt`  in  1  request accepted when `imem_req`&`imem_gnt`.
- `imem_rvalid`  in  1  response valid. Responses return in order, ≥1 cycle after grant.
- `imem_rdata`  in  32  response instruction.
- `if_valid`  out  1  `if_instr`/`if_pc` valid.
- `if_instr`  out  32  instruction to decode.
- `if_pc`  out  32  PC of `if_instr`.

## Operation
- State:
  - `pc`: next fetch address.
  - `resp_pc`: PC of the next non-discarded response.
  - `outstanding`: granted, not yet returned. Width $clog2(DEPTH+1).
  - `discard`: outstanding responses to drop.
  - FIFO of {instr, pc}, `DEPTH` entries, with occupancy `occ`.
- Request:
  - `imem_req` = `outstanding` + `occ` < `DEPTH`.
  - `imem_addr` = `jmp` ? `jmp_addr` : `pc`.
- Grant: `pc` <= `imem_addr` + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0). `outstanding` increments.
- Response (`imem_rvalid`): `outstanding` decrements.
  - If `discard`>0: decrement `discard` and drop the data.
  - Otherwise: push {`imem_rdata`, `resp_pc`} into the FIFO and set `resp_pc` += 4.
- Output:
  - `if_valid` = `occ`≠0 & ~`jmp`.
  - `if_instr`/`if_pc` = FIFO head.
  - Pop when `if_valid` & ~`stalling`.
- Jump (`jmp`=1), applied at the clock edge:
  - FIFO cleared; the head presented this cycle is dropped, not delivered.
  - `resp_pc` <= `jmp_addr`.
  - `discard` <= `outstanding` − `imem_rvalid`, so every pre-jump in-flight request is dropped.
  - `pc` <= `jmp_addr`, or `jmp_addr`+4 if granted this cycle. A grant in the jump cycle is a live target fetch and is not discarded.
- Simultaneous events:
  - `jmp` overrides `stalling` and any push or pop.
  - Push and pop in the same cycle leave `occ` unchanged.
  - A FIFO push is never blocked, because of the credit rule on `imem_req`.
- `jmp_addr` bits [1:0] are ignored (forced 0).

## Timing
- Reset values, all asynchronous on `rstb` low:
  - `pc` = `resp_pc` = `RESET_PC`.
  - `outstanding` = `discard` = `occ` = 0.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = `RESET_PC`.
- `imem_req` is high in the first cycle after `rstb` rises, with `imem_addr`=`RESET_PC`.
- Latency: grant in cycle N and `rvalid` in N+1 gives `if_valid` in N+2. There is no response-to-output bypass.
- Throughput: with `DEPTH`≥3 and a 1-cycle memory with gnt always high, one instruction per cycle in steady state.
- After `jmp` in cycle J, the first target instruction appears no earlier than J+2. No pre-jump instruction appears after J.
- Reset mid-fetch: all state is cleared and late responses are not tracked. The memory must be reset together with the fetch stage.

## Test plan
- Reset release, gnt=1, 1-cycle memory returning word = address: `if_pc`/`if_instr` stream 0,4,8,… with `if_valid` high from cycle 3 onward, one per cycle.
- `stalling` high for 3 cycles while `if_pc`=8: `if_pc` is held at 8, `imem_req` drops once `outstanding`+`occ`=4, and the stream resumes at 8,12 with no loss or duplication.
- `jmp`=1, `jmp_addr`=32'h100 with 2 requests outstanding and a 3-cycle memory: both old responses are dropped, and the next `if_valid` shows `if_pc`=32'h100, then 32'h104.
- `jmp` and `imem_rvalid` in the same cycle with `outstanding`=1: the response is dropped, `discard` stays 0, and the target fetch is granted that cycle, so `pc`=`jmp_addr`+4.
- gnt held low 5 cycles: `imem_addr` is stable and `outstanding` does not change. Back-to-back `jmp` in 2 cycles: only the second target is delivered.
- Fetch at 32'hFFFF_FFFC: the next `imem_addr` is 32'h0000_0000.

Source files
------------

// File: rtl/xrv_fetch_if.sv
// xrv_fetch_if: instruction-memory and decode-side signals of the xriscv fetch stage.
//   imem_req/imem_addr   fetch request and word-aligned address (fetch -> memory)
//   imem_gnt             request accepted when imem_req & imem_gnt (memory -> fetch)
//   imem_rvalid/rdata    in-order response, at least one cycle after grant (memory -> fetch)
//   if_valid/instr/pc    head instruction and its PC (fetch -> decode)
interface xrv_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc
    );
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/xrv_fetch.sv
// xrv_fetch: instruction-fetch stage; owns the PC, issues pipelined imem requests,
// buffers responses in a DEPTH-entry FIFO and hands {instr, pc} to decode.
//   clk       clock
//   rstb      asynchronous active-low reset
//   stalling  hold the head instruction
//   jmp       redirect fetch to jmp_addr and discard all wrong-path work
//   jmp_addr  redirect target (bits [1:0] ignored)
//   bus       imem request/response and decode outputs (master side)
module xrv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        stalling,
    input  logic        jmp,
    input  logic [31:0] jmp_addr,
    xrv_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, occ_q, occ_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   ipc_q   [DEPTH];
    logic [31:0]   tgt;
    logic          grant, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tgt           = jmp_addr & ~32'h3;
    // Credit rule: in-flight plus buffered never exceeds DEPTH, so a push always has room.
    assign bus.imem_req  = ({1'b0, out_q} + {1'b0, occ_q}) < (CW + 1)'(DEPTH);
    assign bus.imem_addr = jmp ? tgt : pc_q;
    assign grant         = bus.imem_req & bus.imem_gnt;
    assign push          = bus.imem_rvalid & (disc_q == '0) & ~jmp;
    assign bus.if_valid  = (occ_q != '0) & ~jmp;
    assign pop           = bus.if_valid & ~stalling;
    assign bus.if_instr  = instr_q[rd_q];
    assign bus.if_pc     = ipc_q[rd_q];

    always_comb begin
        pc_d      = grant ? bus.imem_addr + 32'd4 : jmp ? tgt : pc_q;
        out_d     = out_q + CW'(grant) - CW'(bus.imem_rvalid);
        // On a jump every still-pending pre-jump response becomes garbage; a grant
        // in the jump cycle is already the target fetch and is not counted.
        disc_d    = jmp ? out_q - CW'(bus.imem_rvalid)
                        : disc_q - CW'(bus.imem_rvalid && disc_q != '0);
        resp_pc_d = jmp ? tgt : push ? resp_pc_q + 32'd4 : resp_pc_q;
        occ_d     = jmp ? '0 : occ_q + CW'(push) - CW'(pop);
        wr_d      = jmp ? '0 : push ? inc(wr_q) : wr_q;
        rd_d      = jmp ? '0 : pop ? inc(rd_q) : rd_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
            occ_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= RESET_PC;
            end
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            occ_q     <= occ_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            if (push) begin
                instr_q[wr_q] <= bus.imem_rdata;
                ipc_q[wr_q]   <= resp_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_xrv_fetch.sv
// tb_xrv_fetch: randomized and directed checks of xrv_fetch against an epoch-tagged
// memory/stream model.
module tb_xrv_fetch;
    localparam logic [31:0] RP = 32'h0000_0000;
    localparam int          D  = 4;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        stalling = 1'b0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_addr = '0;
    int          checks = 0;
    int          errors = 0;

    xrv_fetch_if bus();

    xrv_fetch #(.RESET_PC(RP), .DEPTH(D)) dut (
        .clk(clk), .rstb(rstb), .stalling(stalling), .jmp(jmp), .jmp_addr(jmp_addr), .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] buffered[$];
    logic [31:0] dq[$];
    logic [31:0] m_pc = RP;
    int          epoch = 0, cyc = 0, last_ready = 0, lat_lo = 1, lat_hi = 1;

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        memq.delete();
        buffered.delete();
        m_pc       = RP;
        last_ready = cyc;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs against the
    // model, then advance the model by what the rising edge will do.
    task automatic cycle(input logic j, input logic [31:0] ja, input logic st, input logic g);
        logic        req_e, val_e, rv;
        logic [31:0] addr_e, ja_m;
        mreq_t       r;
        int          rdy;
        @(negedge clk);
        ja_m = ja & ~32'h3;
        rv   = memq.size() != 0 && memq[0].ready <= cyc;
        jmp = j; jmp_addr = ja; stalling = st;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? memfn(memq[0].addr) : $urandom;
        #1;
        req_e  = (memq.size() + buffered.size()) < D;
        addr_e = j ? ja_m : m_pc;
        val_e  = buffered.size() != 0 && !j;
        checks++;
        if (bus.imem_req !== req_e) begin
            errors++;
            $display("FAIL imem_req cyc=%0d: got %b, required %b", cyc, bus.imem_req, req_e);
        end
        checks++;
        if (bus.imem_addr !== addr_e) begin
            errors++;
            $display("FAIL imem_addr cyc=%0d: got %h, required %h", cyc, bus.imem_addr, addr_e);
        end
        checks++;
        if (bus.if_valid !== val_e) begin
            errors++;
            $display("FAIL if_valid cyc=%0d: got %b, required %b", cyc, bus.if_valid, val_e);
        end
        if (val_e) begin
            checks++;
            if (bus.if_pc !== buffered[0]) begin
                errors++;
                $display("FAIL if_pc cyc=%0d: got %h, required %h", cyc, bus.if_pc, buffered[0]);
            end
            checks++;
            if (bus.if_instr !== memfn(buffered[0])) begin
                errors++;
                $display("FAIL if_instr cyc=%0d: got %h, required %h", cyc, bus.if_instr, memfn(buffered[0]));
            end
        end
        if (rv) begin
            r = memq.pop_front();
            if (!j && r.epoch == epoch) buffered.push_back(r.addr);
        end
        if (val_e && !st) dq.push_back(buffered.pop_front());
        if (j) begin
            buffered.delete();
            epoch++;
        end
        if (req_e && g) begin
            rdy = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (rdy < last_ready) rdy = last_ready;
            last_ready = rdy;
            memq.push_back('{addr_e, epoch, rdy});
            m_pc = addr_e + 32'd4;
        end else if (j) begin
            m_pc = ja_m;
        end
        cyc++;
    endtask

    task automatic wait_deliveries(input int n, input string name);
        for (int k = 0; k < 60 && dq.size() < n; k++) cycle(1'b0, $urandom, 1'b0, 1'b1);
        checks++;
        if (dq.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d deliveries, required %0d", name, dq.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        @(negedge clk);
        #1;
        checks += 5;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset if_valid: got %b, required 0", bus.if_valid); end
        if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset if_instr: got %h, required 0", bus.if_instr); end
        if (bus.if_pc !== RP) begin errors++; $display("FAIL reset if_pc: got %h, required %h", bus.if_pc, RP); end
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset imem_req: got %b, required 1", bus.imem_req); end
        if (bus.imem_addr !== RP) begin errors++; $display("FAIL reset imem_addr: got %h, required %h", bus.imem_addr, RP); end
        rstb = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        lat_lo = 1; lat_hi = 1;
        dq.delete();
        for (int i = 0; i < 12; i++) cycle(1'b0, $urandom, 1'b0, 1'b1);
        checks++;
        if (dq.size() != 10) begin
            errors++;
            $display("FAIL stream count: got %0d, required 10", dq.size());
        end
        for (int i = 0; i < dq.size(); i++) begin
            checks++;
            if (dq[i] !== RP + 32'(4 * i)) begin
                errors++;
                $display("FAIL stream pc[%0d]: got %h, required %h", i, dq[i], RP + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        cycle(1'b0, $urandom, 1'b1, 1'b1);
        held = bus.if_pc;
        cycle(1'b0, $urandom, 1'b1, 1'b1);
        cycle(1'b0, $urandom, 1'b1, 1'b1);
        checks += 2;
        if (bus.if_pc !== held) begin errors++; $display("FAIL stall hold: got %h, required %h", bus.if_pc, held); end
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall credit: imem_req got %b, required 0", bus.imem_req); end
        dq.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, $urandom, 1'b0, 1'b1);
        wait_deliveries(2, "stall resume");
        if (dq.size() >= 2) begin
            checks += 2;
            if (dq[0] !== held) begin errors++; $display("FAIL stall resume0: got %h, required %h", dq[0], held); end
            if (dq[1] !== held + 32'd4) begin errors++; $display("FAIL stall resume1: got %h, required %h", dq[1], held + 32'd4); end
        end
    endtask

    task automatic test_jump();
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 6; i++) cycle(1'b0, $urandom, 1'b0, 1'b1);
        cycle(1'b1, 32'h100, 1'b0, 1'b1);
        dq.delete();
        wait_deliveries(2, "jump");
        if (dq.size() >= 2) begin
            checks += 2;
            if (dq[0] !== 32'h100) begin errors++; $display("FAIL jump first: got %h, required 00000100", dq[0]); end
            if (dq[1] !== 32'h104) begin errors++; $display("FAIL jump second: got %h, required 00000104", dq[1]); end
        end
    endtask

    task automatic test_jmp_rvalid();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 10; i++) cycle(1'b0, $urandom, 1'b0, 1'b0);
        cycle(1'b0, $urandom, 1'b0, 1'b1);
        cycle(1'b1, 32'h200, 1'b0, 1'b1);
        dq.delete();
        cycle(1'b0, $urandom, 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h204) begin
            errors++;
            $display("FAIL jmp_rvalid pc: got %h, required 00000204", bus.imem_addr);
        end
        wait_deliveries(1, "jmp_rvalid");
        if (dq.size() >= 1) begin
            checks++;
            if (dq[0] !== 32'h200) begin errors++; $display("FAIL jmp_rvalid first: got %h, required 00000200", dq[0]); end
        end
    endtask

    task automatic test_gnt_low_and_back_to_back();
        logic [31:0] a0;
        lat_lo = 1; lat_hi = 3;
        cycle(1'b0, $urandom, 1'b1, 1'b0);
        a0 = bus.imem_addr;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, $urandom, 1'b1, 1'b0);
            checks++;
            if (bus.imem_addr !== a0) begin errors++; $display("FAIL gnt_low addr: got %h, required %h", bus.imem_addr, a0); end
        end
        cycle(1'b1, 32'h300, 1'b0, 1'b1);
        cycle(1'b1, 32'h400, 1'b0, 1'b1);
        dq.delete();
        wait_deliveries(2, "back_to_back");
        if (dq.size() >= 2) begin
            checks += 2;
            if (dq[0] !== 32'h400) begin errors++; $display("FAIL back_to_back first: got %h, required 00000400", dq[0]); end
            if (dq[1] !== 32'h404) begin errors++; $display("FAIL back_to_back second: got %h, required 00000404", dq[1]); end
        end
    endtask

    task automatic test_wrap();
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        dq.delete();
        cycle(1'b0, $urandom, 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap addr: got %h, required 00000000", bus.imem_addr); end
        wait_deliveries(2, "wrap");
        if (dq.size() >= 2) begin
            checks += 2;
            if (dq[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap first: got %h, required fffffffc", dq[0]); end
            if (dq[1] !== 32'h0) begin errors++; $display("FAIL wrap second: got %h, required 00000000", dq[1]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ja;
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            ja = ($urandom % 8 == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom;
            cycle($urandom % 16 == 0, ja, $urandom % 4 == 0, $urandom % 4 != 0);
        end
    endtask

    task automatic test_reset_mid();
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 5; i++) cycle(1'b0, $urandom, 1'b0, 1'b1);
        @(negedge clk);
        jmp = 1'b0; stalling = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        #2;
        rstb = 1'b0;
        #1;
        checks += 3;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL mid_reset if_valid: got %b, required 0", bus.if_valid); end
        if (bus.if_pc !== RP) begin errors++; $display("FAIL mid_reset if_pc: got %h, required %h", bus.if_pc, RP); end
        if (bus.imem_addr !== RP) begin errors++; $display("FAIL mid_reset imem_addr: got %h, required %h", bus.imem_addr, RP); end
        @(negedge clk);
        #1;
        rstb = 1'b1;
        model_reset();
        dq.delete();
        lat_lo = 1; lat_hi = 1;
        wait_deliveries(3, "mid_reset");
        if (dq.size() >= 3) begin
            checks++;
            if (dq[0] !== RP) begin errors++; $display("FAIL mid_reset first: got %h, required %h", dq[0], RP); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_jmp_rvalid();
        test_gnt_low_and_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
